// File: rtl/d_e_pipe_reg.sv
// rtl/d_e_pipe_reg.sv - D/E pipeline register with bubble, flush, hold and Tnew aging (optional DE_BD_FLAG_EN)
module d_e_pipe_reg #(
    parameter int DW = 32,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          hold,
    input  logic [DW-1:0] D_PC,
    input  logic [DW-1:0] D_Instr,
    input  logic [DW-1:0] D_RD1,
    input  logic [DW-1:0] D_RD2,
    input  logic [DW-1:0] D_Imme32,
    input  logic [4:0]    D_A3,
    input  logic [TW-1:0] D_Tnew,
`ifdef DE_BD_FLAG_EN
    input  logic          D_BD,
    output logic          E_BD,
`endif
    output logic [DW-1:0] E_PC,
    output logic [DW-1:0] E_Instr,
    output logic [DW-1:0] E_RD1,
    output logic [DW-1:0] E_RD2,
    output logic [DW-1:0] E_Imme32,
    output logic [4:0]    E_A3,
    output logic [TW-1:0] E_Tnew,
    output logic          E_valid
);

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [4:0]    a3_q, a3_d;
    logic [TW-1:0] tnew_q, tnew_d;
    logic          valid_q, valid_d;
`ifdef DE_BD_FLAG_EN
    logic          bd_q, bd_d;
`endif

    // Tnew counts down one per stage advanced (or per held cycle) and never wraps.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        if (t == '0) begin
            tnew_dec = '0;
        end else begin
            tnew_dec = t - TW'(1);
        end
    endfunction

    always_comb begin
        pc_d    = D_PC;
        instr_d = D_Instr;
        rd1_d   = D_RD1;
        rd2_d   = D_RD2;
        imm_d   = D_Imme32;
        a3_d    = D_A3;
        tnew_d  = tnew_dec(D_Tnew);
        valid_d = 1'b1;
`ifdef DE_BD_FLAG_EN
        bd_d    = D_BD;
`endif
        if (flush || (!hold && stall)) begin
            pc_d    = '0;
            instr_d = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            a3_d    = '0;
            tnew_d  = '0;
            valid_d = 1'b0;
`ifdef DE_BD_FLAG_EN
            bd_d    = 1'b0;
`endif
        end else if (hold) begin
            // Frozen for the MDU; only Tnew keeps maturing so hazards resolve.
            pc_d    = pc_q;
            instr_d = instr_q;
            rd1_d   = rd1_q;
            rd2_d   = rd2_q;
            imm_d   = imm_q;
            a3_d    = a3_q;
            tnew_d  = tnew_dec(tnew_q);
            valid_d = valid_q;
`ifdef DE_BD_FLAG_EN
            bd_d    = bd_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
`ifdef DE_BD_FLAG_EN
            bd_q    <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            valid_q <= valid_d;
`ifdef DE_BD_FLAG_EN
            bd_q    <= bd_d;
`endif
        end
    end

    assign E_PC     = pc_q;
    assign E_Instr  = instr_q;
    assign E_RD1    = rd1_q;
    assign E_RD2    = rd2_q;
    assign E_Imme32 = imm_q;
    assign E_A3     = a3_q;
    assign E_Tnew   = tnew_q;
    assign E_valid  = valid_q;
`ifdef DE_BD_FLAG_EN
    assign E_BD     = bd_q;
`endif

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// tb/tb_d_e_pipe_reg.sv - table-driven self-checking bench for d_e_pipe_reg
module tb_d_e_pipe_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic        bd;
    } d_t;

    typedef struct {
        logic stall;
        logic flush;
        logic hold;
        d_t   din;
        d_t   exp_e;
        logic exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] D_PC = '0, D_Instr = '0, D_RD1 = '0, D_RD2 = '0, D_Imme32 = '0;
    logic [4:0]  D_A3 = '0;
    logic [1:0]  D_Tnew = '0;
    logic        D_BD = 1'b0;
    logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_Imme32;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew;
    logic        E_valid;
    logic        E_BD;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    d_e_pipe_reg #(.DW(32), .TW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .hold     (hold),
        .D_PC     (D_PC),
        .D_Instr  (D_Instr),
        .D_RD1    (D_RD1),
        .D_RD2    (D_RD2),
        .D_Imme32 (D_Imme32),
        .D_A3     (D_A3),
        .D_Tnew   (D_Tnew),
`ifdef DE_BD_FLAG_EN
        .D_BD     (D_BD),
        .E_BD     (E_BD),
`endif
        .E_PC     (E_PC),
        .E_Instr  (E_Instr),
        .E_RD1    (E_RD1),
        .E_RD2    (E_RD2),
        .E_Imme32 (E_Imme32),
        .E_A3     (E_A3),
        .E_Tnew   (E_Tnew),
        .E_valid  (E_valid)
    );

`ifndef DE_BD_FLAG_EN
    assign E_BD = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_e(input string tag, input d_t e, input logic v);
        chk({tag, " E_PC"},     E_PC,     e.pc);
        chk({tag, " E_Instr"},  E_Instr,  e.instr);
        chk({tag, " E_RD1"},    E_RD1,    e.rd1);
        chk({tag, " E_RD2"},    E_RD2,    e.rd2);
        chk({tag, " E_Imme32"}, E_Imme32, e.imm);
        chk({tag, " E_A3"},     {27'd0, E_A3},   {27'd0, e.a3});
        chk({tag, " E_Tnew"},   {30'd0, E_Tnew}, {30'd0, e.tnew});
        chk({tag, " E_valid"},  {31'd0, E_valid}, {31'd0, v});
`ifdef DE_BD_FLAG_EN
        chk({tag, " E_BD"},     {31'd0, E_BD},   {31'd0, e.bd});
`endif
    endtask

    task automatic drive(input logic s, input logic f, input logic h, input d_t d);
        stall    = s;
        flush    = f;
        hold     = h;
        D_PC     = d.pc;
        D_Instr  = d.instr;
        D_RD1    = d.rd1;
        D_RD2    = d.rd2;
        D_Imme32 = d.imm;
        D_A3     = d.a3;
        D_Tnew   = d.tnew;
        D_BD     = d.bd;
    endtask

    d_t   A, B, C, X, D, E, Z;
    d_t   A1, B2, C2, C1, C0, D0, E0;
    vec_t vec[16];

    initial begin
        A = '{32'h3000, 32'h24050001, 32'h11,  32'h22,  32'hFFFF8000, 5'd5,  2'd2, 1'b1};
        B = '{32'h3004, 32'h8C220004, 32'h100, 32'h200, 32'h4,        5'd2,  2'd3, 1'b0};
        C = '{32'h3008, 32'h00000018, 32'h7,   32'h9,   32'h18,       5'd0,  2'd3, 1'b1};
        X = '{32'h300C, 32'hDEADBEEF, 32'h1,   32'h2,   32'h3,        5'd31, 2'd3, 1'b1};
        D = '{32'h3010, 32'h3C01ABCD, 32'h5,   32'h6,   32'hABCD,     5'd1,  2'd0, 1'b0};
        E = '{32'h3014, 32'h8C230008, 32'hA,   32'hB,   32'h8,        5'd3,  2'd1, 1'b1};
        Z = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0};
        A1 = A; A1.tnew = 2'd1;
        B2 = B; B2.tnew = 2'd2;
        C2 = C; C2.tnew = 2'd2;
        C1 = C; C1.tnew = 2'd1;
        C0 = C; C0.tnew = 2'd0;
        D0 = D;
        E0 = E; E0.tnew = 2'd0;

        //          stall flush hold  D   expected E  valid
        vec[0]  = '{1'b0, 1'b0, 1'b0, A, A1, 1'b1};
        vec[1]  = '{1'b1, 1'b0, 1'b0, B, Z,  1'b0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, B, B2, 1'b1};
        vec[3]  = '{1'b0, 1'b0, 1'b0, C, C2, 1'b1};
        vec[4]  = '{1'b0, 1'b0, 1'b1, X, C1, 1'b1};
        vec[5]  = '{1'b0, 1'b0, 1'b1, X, C0, 1'b1};
        vec[6]  = '{1'b0, 1'b0, 1'b1, X, C0, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 1'b1, X, C0, 1'b1};
        vec[8]  = '{1'b0, 1'b1, 1'b1, X, Z,  1'b0};
        vec[9]  = '{1'b0, 1'b0, 1'b0, D, D0, 1'b1};
        vec[10] = '{1'b0, 1'b0, 1'b1, X, D0, 1'b1};
        vec[11] = '{1'b0, 1'b1, 1'b0, X, Z,  1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b1, X, Z,  1'b0};
        vec[13] = '{1'b0, 1'b0, 1'b0, E, E0, 1'b1};
        vec[14] = '{1'b1, 1'b1, 1'b0, X, Z,  1'b0};
        vec[15] = '{1'b1, 1'b0, 1'b1, X, Z,  1'b0};

        // Load something, then assert reset mid-cycle: outputs clear without an edge.
        drive(1'b0, 1'b0, 1'b0, A);
        @(posedge clk); #1;
        check_e("pre-reset load", A1, 1'b1);
        #2 reset = 1'b0;
        #1 check_e("async reset", Z, 1'b0);
        @(posedge clk); #1;
        check_e("reset held", Z, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].stall, vec[i].flush, vec[i].hold, vec[i].din);
            @(posedge clk); #1;
            check_e($sformatf("v%0d", i), vec[i].exp_e, vec[i].exp_valid);
        end

        // Reset in the middle of a hold: nothing of the held instruction survives.
        drive(1'b0, 1'b0, 1'b0, C);
        @(posedge clk); #1;
        check_e("mid-hold load", C2, 1'b1);
        drive(1'b0, 1'b0, 1'b1, X);
        #2 reset = 1'b0;
        #1 check_e("mid-hold reset", Z, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_e("hold after reset", Z, 1'b0);
        drive(1'b0, 1'b0, 1'b0, E);
        @(posedge clk); #1;
        check_e("load after reset", E0, 1'b1);

        // Reset in the middle of a flush.
        drive(1'b0, 1'b1, 1'b0, X);
        #2 reset = 1'b0;
        #1 check_e("mid-flush reset", Z, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, B);
        @(posedge clk); #1;
        check_e("load after flush reset", B2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/d_e_pipe_reg.md
Name: d_e_pipe_reg

Overview:
- D/E pipeline register of the 5-stage MIPS core.
- Directly consumes the D-stage immediate extender output (32-bit extended immediate), plus PC, instruction, GRF read data, write-back address and Tnew.
- Presents those values to the E stage.
- Implements hazard-unit bubble insertion, a flush, and an E-stage hold (used while the multiply/divide unit is busy), with Tnew aging during the hold.

Parameters:
- DW, 32, data path width for PC, instruction, register data and immediate.
- TW, 2, width of the Tnew field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall; insert a bubble into E.
- flush  input  1  discard the D-stage instruction and clear E.
- hold  input  1  freeze E contents (MDU busy).
- D_PC  input  DW  D-stage PC.
- D_Instr  input  DW  D-stage instruction word.
- D_RD1  input  DW  forwarded rs value.
- D_RD2  input  DW  forwarded rt value.
- D_Imme32  input  DW  extended immediate from the D-stage extender.
- D_A3  input  5  destination register number (0 = no write).
- D_Tnew  input  TW  cycles until the result is ready, counted from D.
- E_PC, E_Instr, E_RD1, E_RD2, E_Imme32  output  DW  registered copies.
- E_A3  output  5  registered destination.
- E_Tnew  output  TW  remaining Tnew as seen in E.
- E_valid  output  1  1 = E holds a real instruction, 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0 immediately, including E_valid=0 and E_Tnew=0. Release is sampled on the next clk rising edge.
- Latency: 1 cycle. Values present at edge N appear on the E_* outputs after edge N.
- Per-edge priority (highest first):
  - flush: load a bubble.
  - hold: keep all fields.
  - stall: load a bubble.
  - normal: load the D_* inputs.
- Bubble:
  - E_PC, E_Instr, E_RD1, E_RD2 and E_Imme32 are 0.
  - E_A3=0, E_Tnew=0, E_valid=0.
  - E_Instr=0 is a nop.
- Normal load:
  - Capture all D_* fields and set E_valid=1.
  - E_Tnew = D_Tnew-1, saturating at 0 (D_Tnew=0 gives 0).
- Hold:
  - All data fields and E_valid are unchanged.
  - E_Tnew = E_Tnew-1, saturating at 0, so the hazard unit sees the result maturing.
  - A hold on a bubble leaves the bubble in place.
- stall and hold both high: hold wins. E is frozen; the upstream F/D stage is frozen by the hazard unit, so no instruction is lost.
- flush and hold both high: flush wins. E becomes a bubble; the MDU's own control drops hold.
- Reset asserted mid-hold or mid-flush: outputs clear asynchronously and no pending state survives.
- No combinational path from any input to any output; every output comes directly from a flop.
- D_A3=0 is passed through unchanged. Consumers treat A3=0 as no write. E_Tnew is not forced for A3=0.

Optional Feature:
- Macro: DE_BD_FLAG_EN.
- Defined:
  - Adds input D_BD (1 bit, D instruction is in a branch delay slot) and output E_BD (1 bit).
  - E_BD follows the same load/hold/bubble/flush/reset rules as the data fields; bubble and reset value is 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset then normal load: reset=0 mid-cycle clears all outputs asynchronously. Then reset=1 and D_PC=0x3000, D_Imme32=0xFFFF8000, D_A3=5, D_Tnew=2. After one edge: E_PC=0x3000, E_Imme32=0xFFFF8000, E_A3=5, E_Tnew=1, E_valid=1.
- Stall bubble: stall=1 with D_Instr=0x8C220004 -> after the edge E_Instr=0, E_A3=0, E_Tnew=0, E_valid=0. Next edge with stall=0 -> E_Instr=0x8C220004.
- Hold aging: load D_Tnew=3 (E_Tnew=2), then hold=1 for 3 edges -> E_Tnew goes 1, 0, 0. E_PC and E_Imme32 stay unchanged and E_valid stays 1.
- Priority: stall=1 with hold=1 -> E unchanged. flush=1 with hold=1 -> bubble with E_valid=0.
- Saturation: D_Tnew=0 -> E_Tnew=0. A subsequent hold keeps E_Tnew=0 with no wrap to 3.
- DE_BD_FLAG_EN defined: D_BD=1 load gives E_BD=1. A stall bubble gives E_BD=0. Reset gives E_BD=0.
